// File: rtl/quad_step_decoder.sv
// Quadrature decoder: synchronises and de-glitches encoder phases A/B, then emits
// one-cycle step pulses with direction, a saturating position and a sticky error flag.
module quad_step_decoder #(
   parameter int FILTER_LEN = 3,
   parameter int POS_MAX    = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       quad_a,
   input  logic       quad_b,
   input  logic       clear,
   output logic       step,
   output logic       dir,
   output logic [7:0] pos,
   output logic       err,
   output logic [1:0] phase
);

   typedef enum logic [1:0] {
      P00 = 2'b00,
      P01 = 2'b01,
      P11 = 2'b11,
      P10 = 2'b10
   } phase_t;

   localparam logic [3:0] FILT_CNT = 4'(FILTER_LEN);
   localparam logic [7:0] POS_LIM  = 8'(POS_MAX);

   logic       a_s1, a_s2, b_s1, b_s2;
   logic [1:0] s;
   phase_t     phase_q, phase_d, phase_nxt;
   logic [1:0] cand_q, cand_nxt;
   logic [3:0] cnt_q, cnt_nxt, cnt_inc;
   logic       up, down, jump;
   logic [7:0] pos_nxt;

   // Successor of a phase in the forward (up) rotation.
   function automatic phase_t fwd(input phase_t p);
      case (p)
         P00:     fwd = P01;
         P01:     fwd = P11;
         P11:     fwd = P10;
         default: fwd = P00;
      endcase
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_s1 <= 1'b0;
         a_s2 <= 1'b0;
         b_s1 <= 1'b0;
         b_s2 <= 1'b0;
      end else begin
         a_s1 <= quad_a;
         a_s2 <= a_s1;
         b_s1 <= quad_b;
         b_s2 <= b_s1;
      end
   end

   assign s = {a_s2, b_s2};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cand_nxt  = cand_q;
      cnt_nxt   = cnt_q;
      cnt_inc   = cnt_q;
      phase_nxt = phase_q;
      if (s == phase_q) begin
         cnt_nxt = 4'd0;
      end else begin
         if (s != cand_q) begin
            cand_nxt = s;
            cnt_inc  = 4'd1;
         end else begin
            cnt_inc  = cnt_q + 4'd1;
         end
         if (cnt_inc == FILT_CNT) begin
            phase_nxt = phase_t'(cand_nxt);
            cnt_nxt   = 4'd0;
         end else begin
            cnt_nxt   = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= P00;
         cand_q  <= 2'b00;
         cnt_q   <= 4'd0;
      end else begin
         phase_q <= phase_nxt;
         cand_q  <= cand_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // phase_d lags phase_q by one cycle; a difference between them is an accepted transition.
   always_comb begin
      up      = (phase_q == fwd(phase_d));
      down    = (phase_d == fwd(phase_q));
      jump    = ((phase_q ^ phase_d) == 2'b11);
      pos_nxt = pos;
      if (clear)
         pos_nxt = 8'd0;
      else if (up && (pos < POS_LIM))
         pos_nxt = pos + 8'd1;
      else if (down && (pos != 8'd0))
         pos_nxt = pos - 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_d <= P00;
         step    <= 1'b0;
         dir     <= 1'b0;
         pos     <= 8'd0;
         err     <= 1'b0;
      end else begin
         phase_d <= phase_q;
         step    <= up | down;
         pos     <= pos_nxt;
         if (up || down)
            dir <= up;
         // An illegal jump wins over a simultaneous clear.
         if (jump)
            err <= 1'b1;
         else if (clear)
            err <= 1'b0;
      end
   end

   assign phase = phase_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Self-checking bench for quad_step_decoder: vector table plus step scoreboard,
// with a second instance for FILTER_LEN=1 / POS_MAX=5 saturation.
module tb_quad_step_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       quad_a, quad_b, clear;
   logic       step, dir, err;
   logic [7:0] pos;
   logic [1:0] phase;

   logic       sa, sb, s_clear;
   logic       s_step, s_dir, s_err;
   logic [7:0] s_pos;
   logic [1:0] s_phase;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int sat_steps = 0;

   typedef struct {
      logic a;
      logic b;
      int   hold;
      logic exp_step;
      logic exp_dir;
      int   exp_pos;
      logic exp_err;
   } vec_t;

   typedef struct {
      int   cyc;
      logic dir;
      int   pos;
      logic err;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   exp_t mon_e;

   quad_step_decoder #(.FILTER_LEN(3), .POS_MAX(255)) u_dut (
      .clk(clk), .rst(rst), .quad_a(quad_a), .quad_b(quad_b), .clear(clear),
      .step(step), .dir(dir), .pos(pos), .err(err), .phase(phase)
   );

   quad_step_decoder #(.FILTER_LEN(1), .POS_MAX(5)) u_sat (
      .clk(clk), .rst(rst), .quad_a(sa), .quad_b(sb), .clear(s_clear),
      .step(s_step), .dir(s_dir), .pos(s_pos), .err(s_err), .phase(s_phase)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic a, input logic b, input logic st,
                               input logic d, input int p, input logic e);
      vec_t v;
      v.a = a; v.b = b; v.hold = 8;
      v.exp_step = st; v.exp_dir = d; v.exp_pos = p; v.exp_err = e;
      return v;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // A pin change driven just after edge k is sampled at k+1 and the step lands on edge k+6.
   task automatic drive(input logic a, input logic b);
      quad_a = a;
      quad_b = b;
   endtask

   task automatic expect_step(input logic d, input int p, input logic e);
      exp_t x;
      x.cyc = cyc + 6; x.dir = d; x.pos = p; x.err = e;
      sb_q.push_back(x);
   endtask

   task automatic check_state(input string tag, input int ph, input int p,
                              input logic d, input logic e);
      check({tag, "_phase"}, phase, ph);
      check({tag, "_pos"}, pos, p);
      check({tag, "_dir"}, dir, d);
      check({tag, "_err"}, err, e);
   endtask

   // Scoreboard: every step pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!rst && step) begin
         if (sb_q.size() == 0) begin
            check("stray_step", step, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check("step_cycle", cyc, mon_e.cyc);
            check("step_dir", dir, mon_e.dir);
            check("step_pos", pos, mon_e.pos);
            check("step_err", err, mon_e.err);
         end
      end
   end

   always @(negedge clk) if (!rst && s_step) sat_steps++;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; quad_a = 1'b0; quad_b = 1'b0; clear = 1'b0;
      sa = 1'b0; sb = 1'b0; s_clear = 1'b0;

      vecs.push_back(mk(0, 1, 1, 1, 1, 0));
      vecs.push_back(mk(1, 1, 1, 1, 2, 0));
      vecs.push_back(mk(1, 0, 1, 1, 3, 0));
      vecs.push_back(mk(0, 0, 1, 1, 4, 0));
      vecs.push_back(mk(1, 0, 1, 0, 3, 0));
      vecs.push_back(mk(1, 1, 1, 0, 2, 0));
      vecs.push_back(mk(0, 1, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 2, 0));
      vecs.push_back(mk(1, 1, 0, 1, 2, 1));
      vecs.push_back(mk(1, 0, 1, 1, 3, 1));
      vecs.push_back(mk(0, 0, 1, 1, 4, 1));

      wait_cycles(3);
      rst = 1'b0;
      check("reset_step", step, 0);
      check_state("reset", 0, 0, 1'b0, 1'b0);

      // Table: forward walk, reverse walk through zero saturation, illegal jump, sticky err.
      foreach (vecs[i]) begin
         drive(vecs[i].a, vecs[i].b);
         if (vecs[i].exp_step)
            expect_step(vecs[i].exp_dir, vecs[i].exp_pos, vecs[i].exp_err);
         wait_cycles(vecs[i].hold);
         check_state($sformatf("vec%0d", i), {vecs[i].a, vecs[i].b},
                     vecs[i].exp_pos, vecs[i].exp_dir, vecs[i].exp_err);
      end

      // Glitch of 2 samples is rejected; 3 samples is accepted in both directions.
      drive(0, 1);
      wait_cycles(2);
      drive(0, 0);
      wait_cycles(10);
      check_state("glitch2", 0, 4, 1'b1, 1'b1);
      drive(0, 1);
      expect_step(1'b1, 5, 1'b1);
      wait_cycles(3);
      drive(0, 0);
      expect_step(1'b0, 4, 1'b1);
      wait_cycles(10);
      check_state("glitch3", 0, 4, 1'b0, 1'b1);

      // Climb to pos 7, ending at phase 10.
      drive(0, 1); expect_step(1'b1, 5, 1'b1); wait_cycles(8);
      drive(1, 1); expect_step(1'b1, 6, 1'b1); wait_cycles(8);
      drive(1, 0); expect_step(1'b1, 7, 1'b1); wait_cycles(8);
      check_state("pos7", 2, 7, 1'b1, 1'b1);

      // Clear coinciding with an up step: step still pulses, pos and err are zeroed.
      drive(0, 0);
      expect_step(1'b1, 0, 1'b0);
      wait_cycles(5);
      clear = 1'b1;
      wait_cycles(1);
      clear = 1'b0;
      wait_cycles(4);
      check_state("clr_step", 0, 0, 1'b1, 1'b0);

      // Illegal jump coinciding with clear leaves err set.
      drive(1, 1);
      wait_cycles(5);
      clear = 1'b1;
      wait_cycles(1);
      clear = 1'b0;
      wait_cycles(4);
      check_state("clr_jump", 3, 0, 1'b1, 1'b1);

      drive(1, 0);
      expect_step(1'b1, 1, 1'b1);
      wait_cycles(8);
      check_state("after_jump", 2, 1, 1'b1, 1'b1);
      clear = 1'b1;
      wait_cycles(1);
      clear = 1'b0;
      check_state("clear_only", 2, 0, 1'b1, 1'b0);

      // Up saturation on the FILTER_LEN=1, POS_MAX=5 instance.
      for (int i = 0; i < 7; i++) begin
         case (i % 4)
            0: begin sa = 1'b0; sb = 1'b1; end
            1: begin sa = 1'b1; sb = 1'b1; end
            2: begin sa = 1'b1; sb = 1'b0; end
            default: begin sa = 1'b0; sb = 1'b0; end
         endcase
         wait_cycles(4);
      end
      wait_cycles(4);
      check("sat_pos", s_pos, 5);
      check("sat_steps", sat_steps, 7);
      check("sat_dir", s_dir, 1);
      check("sat_phase", s_phase, 2);

      // Asynchronous reset in the middle of a filter count.
      drive(0, 0);
      wait_cycles(3);
      check("queue_before_rst", sb_q.size(), 0);
      rst = 1'b1;
      #1;
      check("rst_step", step, 0);
      check_state("rst_async", 0, 0, 1'b0, 1'b0);
      check("rst_sat_pos", s_pos, 0);
      check("rst_sat_phase", s_phase, 0);
      sa = 1'b0; sb = 1'b0;
      wait_cycles(2);
      rst = 1'b0;
      wait_cycles(15);
      check_state("post_rst", 0, 0, 1'b0, 1'b0);
      check("pending_steps", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
